// File: rtl/key_loader_if.sv
// ============================================================================
// Module      : key_loader_if
// Description : Handshake/bus bundle between secure key storage, the key
//               loader and the locked netlist.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_loader_if #(
    parameter int KEY_W = 20
);
    logic             start;
    logic             clear;
    logic             sdi;
    logic             sdi_valid;
    logic             sdi_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_applied;
    logic             busy;
    logic             load_err;
    logic             lockout;

    modport master (
        output start, clear, sdi, sdi_valid,
        input  sdi_ready, key_out, key_applied, busy, load_err, lockout
    );

    modport slave (
        input  start, clear, sdi, sdi_valid,
        output sdi_ready, key_out, key_applied, busy, load_err, lockout
    );
endinterface

`default_nettype wire

// File: rtl/key_loader.sv
// ============================================================================
// Module      : key_loader
// Description : Serial parity-checked key loader for a logic-locked netlist.
//               Optional lockout after MAX_FAIL consecutive failed loads,
//               enabled by defining KEY_LOADER_LOCKOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_loader #(
    parameter int KEY_W    = 20,
    parameter int MAX_FAIL = 3
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    key_loader_if.slave  bus
);

    localparam int c_CNT_W = $clog2(KEY_W + 2);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_LOAD    = 2'd1;
    localparam logic [1:0] c_CHECK   = 2'd2;
    localparam logic [1:0] c_LOCKOUT = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [KEY_W-1:0]   r_shadow;
    logic               r_par;
    logic [KEY_W-1:0]   r_key;
    logic               r_applied;
    logic               r_err;

    logic w_accept;
    logic w_last;
    logic w_pass;
    logic w_clear;
    logic w_to_lock;

    assign w_accept = (r_state == c_LOAD) && bus.sdi_valid;
    assign w_last   = (r_cnt == c_CNT_W'(KEY_W));
    // r_par accumulates key bits and the parity bit: zero means even count.
    assign w_pass   = ~r_par;
    assign w_clear  = bus.clear && (r_state != c_LOCKOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_par     <= 1'b0;
            r_key     <= '0;
            r_applied <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_clear) begin
            r_state   <= c_IDLE;
            r_key     <= '0;
            r_applied <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_state  <= c_LOAD;
                        r_cnt    <= '0;
                        r_shadow <= '0;
                        r_par    <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                c_LOAD: begin
                    if (w_accept) begin
                        r_par <= r_par ^ bus.sdi;
                        r_cnt <= r_cnt + 1'b1;
                        // Shift in from the top so the first bit lands in bit 0.
                        if (!w_last) begin
                            r_shadow <= {bus.sdi, r_shadow[KEY_W-1:1]};
                        end else begin
                            r_state <= c_CHECK;
                        end
                    end
                end
                c_CHECK: begin
                    if (w_pass) begin
                        r_key     <= r_shadow;
                        r_applied <= 1'b1;
                        r_state   <= c_IDLE;
                    end else begin
                        r_key     <= '0;
                        r_applied <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= w_to_lock ? c_LOCKOUT : c_IDLE;
                    end
                end
                c_LOCKOUT: begin
                    r_state <= c_LOCKOUT;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef KEY_LOADER_LOCKOUT_EN
    localparam int c_FAIL_W = $clog2(MAX_FAIL + 1);

    logic [c_FAIL_W-1:0] r_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail <= '0;
        end else if (!w_clear && (r_state == c_CHECK)) begin
            r_fail <= w_pass ? '0 : r_fail + 1'b1;
        end
    end

    assign w_to_lock   = (r_fail == c_FAIL_W'(MAX_FAIL - 1));
    assign bus.lockout = (r_state == c_LOCKOUT);
`else
    logic w_unused_max_fail;

    assign w_unused_max_fail = (MAX_FAIL == 0);
    assign w_to_lock         = 1'b0;
    assign bus.lockout       = 1'b0;
`endif

    assign bus.key_out     = r_key;
    assign bus.key_applied = r_applied;
    assign bus.load_err    = r_err;
    assign bus.sdi_ready   = (r_state == c_LOAD);
    assign bus.busy        = (r_state == c_LOAD) || (r_state == c_CHECK);

endmodule

`default_nettype wire

// File: tb/tb_key_loader.sv
// ============================================================================
// Module      : tb_key_loader
// Description : Self-checking bench for key_loader: directed scenarios plus
//               randomized loads against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_loader;

    localparam int KW = 20;
    localparam int MF = 3;
`ifdef KEY_LOADER_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    key_loader_if #(.KEY_W(KW)) bus ();

    key_loader #(
        .KEY_W    (KW),
        .MAX_FAIL (MF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the outputs should be between loads.
    logic [KW-1:0] m_key;
    logic          m_applied;
    logic          m_err;
    logic          m_lock;
    int            m_fails;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_key     = '0;
        m_applied = 1'b0;
        m_err     = 1'b0;
        m_lock    = 1'b0;
        m_fails   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_key"},     bus.key_out,     m_key);
        check_eq({tag, "_applied"}, bus.key_applied, m_applied);
        check_eq({tag, "_err"},     bus.load_err,    m_err);
        check_eq({tag, "_lock"},    bus.lockout,     m_lock);
    endtask

    // Full load: KW key bits LSB first then the parity bit; optional gaps.
    task automatic do_load(input logic [KW-1:0] key, input logic par,
                           input int gap_at, input int gap_len, input bit rnd);
        logic [KW:0] bits;
        int          n_gap;
        bit          pass;
        bits = {par, key};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        m_err = 1'b0;
        check_eq("load_busy",  bus.busy,      1);
        check_eq("load_ready", bus.sdi_ready, 1);
        check_eq("load_errclr", bus.load_err, 0);
        for (int i = 0; i <= KW; i++) begin
            n_gap = (i == gap_at) ? gap_len :
                    (rnd && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(1, 3)) : 0;
            for (int g = 0; g < n_gap; g++) begin
                bus.sdi_valid = 1'b0;
                bus.sdi       = 1'($urandom);
                bus.start     = rnd ? 1'($urandom) : 1'b0;
                step();
                bus.start = 1'b0;
                check_eq("gap_key_hold", bus.key_out, m_key);
                check_eq("gap_busy",     bus.busy,    1);
            end
            bus.sdi_valid = 1'b1;
            bus.sdi       = bits[i];
            bus.start     = rnd ? 1'($urandom) : 1'b0;
            step();
            bus.sdi_valid = 1'b0;
            bus.start     = 1'b0;
            check_eq("bit_key_hold", bus.key_out, m_key);
            if (i < KW) check_eq("bit_ready", bus.sdi_ready, 1);
        end
        check_eq("chk_busy",  bus.busy,      1);
        check_eq("chk_ready", bus.sdi_ready, 0);
        bus.start = rnd ? 1'($urandom) : 1'b0;
        step();
        bus.start = 1'b0;
        pass = ($countones({par, key}) % 2) == 0;
        if (pass) begin
            m_key = key; m_applied = 1'b1; m_err = 1'b0; m_fails = 0;
        end else begin
            m_key = '0; m_applied = 1'b0; m_err = 1'b1; m_fails++;
            if (LOCK_EN && m_fails >= MF) m_lock = 1'b1;
        end
        check_outputs("done");
        check_eq("done_busy",  bus.busy,      0);
        check_eq("done_ready", bus.sdi_ready, 0);
    endtask

    task automatic partial(input logic [KW-1:0] key, input int n);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.sdi_valid = 1'b1;
            bus.sdi       = key[i];
            step();
            check_eq("part_key_hold", bus.key_out, m_key);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        check_eq("rst_busy",  bus.busy,      0);
        check_eq("rst_ready", bus.sdi_ready, 0);
        step();
        bus.sdi_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [KW-1:0] key;
        logic          bad;
        bus.start     = 1'b0;
        bus.clear     = 1'b0;
        bus.sdi       = 1'b0;
        bus.sdi_valid = 1'b0;
        rst_n         = 1'b0;
        #2;
        do_reset();

        // Good load, then bad parity, then good load with a 5-cycle gap after bit 7.
        do_load(20'hA5C3F, 1'b0, -1, 0, 1'b0);
        do_load(20'hA5C3F, 1'b1, -1, 0, 1'b0);
        do_load(20'hA5C3F, 1'b0, 8, 5, 1'b0);

        // clear and start together: clear wins, no load starts.
        bus.clear = 1'b1;
        bus.start = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        m_key = '0; m_applied = 1'b0; m_err = 1'b0;
        check_outputs("clrstart");
        check_eq("clrstart_busy", bus.busy, 0);

        // Randomized loads; bad ones only while they cannot trigger lockout.
        for (int t = 0; t < 10; t++) begin
            key = KW'($urandom);
            bad = (m_fails + 1 < MF) && ($urandom_range(0, 3) == 0);
            do_load(key, (^key) ^ bad, -1, 0, 1'b1);
        end
        do_load(KW'($urandom) | 20'h1, 1'b0 ^ (^(KW'(0))), -1, 0, 1'b0);
        key = 20'h5A5A5;
        do_load(key, ^key, -1, 0, 1'b1);

        // clear at bit 10 mid-load.
        partial(20'h12345, 10);
        bus.clear = 1'b1;
        step();
        bus.clear     = 1'b0;
        bus.sdi_valid = 1'b0;
        m_key = '0; m_applied = 1'b0; m_err = 1'b0;
        check_outputs("midclr");
        check_eq("midclr_busy",  bus.busy,      0);
        check_eq("midclr_ready", bus.sdi_ready, 0);

        // Reset at bit 12 mid-load, then a load right after release.
        key = 20'h0F0F3;
        do_load(key, ^key, -1, 0, 1'b0);
        partial(20'h54321, 12);
        do_reset();
        do_load(20'hA5C3F, 1'b0, -1, 0, 1'b0);

        // Three consecutive bad loads.
        for (int t = 0; t < MF; t++) begin
            key = KW'($urandom);
            do_load(key, ~(^key), -1, 0, 1'b0);
        end
        if (m_lock) begin
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            check_eq("lock_start_busy", bus.busy, 0);
            check_outputs("lock_start");
            bus.clear = 1'b1;
            step();
            bus.clear = 1'b0;
            check_outputs("lock_clear");
            check_eq("lock_ready", bus.sdi_ready, 0);
            do_reset();
            check_eq("lock_after_rst", bus.lockout, 0);
        end else begin
            check_eq("nolock_flag", bus.lockout, 0);
            key = 20'h3C3C3;
            do_load(key, ^key, -1, 0, 1'b0);
        end
        do_load(20'hA5C3F, 1'b0, -1, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 20, number of key bits delivered to the locked netlist (two per key-controlled mux).
REQ-002 Parameter MAX_FAIL, default 3, number of consecutive failed loads that trigger lockout.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a key load.
REQ-006 clear  input  1  synchronous zeroize request.
REQ-007 sdi  input  1  serial key data from secure storage.
REQ-008 sdi_valid  input  1  sdi carries a valid bit this cycle.
REQ-009 sdi_ready  output  1  block accepts sdi this cycle.
REQ-010 key_out  output  KEY_W  key bits to the locked netlist; key_out[i] drives key input D_i.
REQ-011 key_applied  output  1  key_out holds a verified key.
REQ-012 busy  output  1  a load is in progress.
REQ-013 load_err  output  1  the last load failed its parity check.
REQ-014 lockout  output  1  the block is permanently locked until reset.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, CHECK and LOCKOUT.
REQ-016 IDLE -> LOAD on start=1; start is ignored in LOAD, CHECK and LOCKOUT.
REQ-017 Entering LOAD SHALL zero the shadow register and the bit counter, and SHALL clear load_err.
REQ-018 In LOAD, sdi_ready=1; a bit is accepted only on a clock edge with sdi_valid=1 and sdi_ready=1.
REQ-019 The block SHALL load KEY_W key bits LSB first (the first accepted bit becomes key bit 0).
REQ-020 The key bits are followed by exactly one even-parity bit, giving KEY_W+1 handshakes in total.
REQ-021 The bit counter SHALL be ceil(log2(KEY_W+2)) bits wide and SHALL never wrap.
REQ-022 Acceptance of the parity bit moves LOAD -> CHECK; sdi_ready=0 in CHECK.
REQ-023 CHECK lasts exactly one cycle, after which the FSM returns to IDLE (or enters LOCKOUT per REQ-034).
REQ-024 CHECK pass (even total count of ones): on that edge key_out <= shadow, key_applied <= 1, and the fail counter clears.
REQ-025 CHECK fail: on that edge key_out <= 0, key_applied <= 0, load_err <= 1, and the fail counter increments.
REQ-026 key_out SHALL change only in CHECK, on clear, or on reset; it SHALL hold its value throughout LOAD.
REQ-027 busy=1 in LOAD and CHECK, and 0 otherwise.
REQ-028 clear=1 takes priority over every other input, in any state except LOCKOUT.
REQ-029 clear=1 SHALL set key_out=0, key_applied=0 and load_err=0, and SHALL return the FSM to IDLE on the next edge.
REQ-030 clear=1 SHALL leave the fail counter unchanged.
REQ-031 clear and start asserted in the same cycle: clear wins and start is dropped.
REQ-032 sdi_valid held low mid-load SHALL stall the load indefinitely, with no timeout.

Reset
REQ-033 rst_n=0 SHALL immediately force the FSM to IDLE and zero the shadow register, counters, key_out, key_applied, load_err and lockout, with sdi_ready=0 and busy=0 (also when asserted mid-load); the first start is honoured on the first edge after rst_n rises.

Configuration
REQ-034 With KEY_LOADER_LOCKOUT_EN defined, the MAX_FAIL-th consecutive CHECK failure SHALL enter LOCKOUT, which forces lockout=1, key_out=0 and sdi_ready=0, ignores start and clear, and is left only by reset.
REQ-035 Without KEY_LOADER_LOCKOUT_EN, the LOCKOUT state and fail counter SHALL be absent and lockout SHALL be tied to 0; failures return to IDLE indefinitely.

Verification
REQ-036 The bench SHALL cover the following directed scenarios.
- Good load: start, then key 20'hA5C3F LSB first plus parity 0 -> key_out=20'hA5C3F and key_applied=1 one edge after the parity handshake, busy=0 thereafter.
- Bad parity: same key with parity 1 -> key_out=0, key_applied=0, load_err=1.
- Valid gaps: sdi_valid low for 5 cycles after bit 7 -> same result as the good load; key_out unchanged during the load.
- Mid-load events: clear at bit 10 -> key_out=0 and IDLE next edge; rst_n low at bit 12 -> all outputs 0 at once.
- Lockout with KEY_LOADER_LOCKOUT_EN: 3 bad loads -> lockout=1, a subsequent start and clear are ignored, and only reset clears it.
- Without the macro: the same 3 bad loads leave lockout=0, and a 4th good load gives key_applied=1.
